// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity mode encodings for the PARITY parameter
    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Data bits per frame; shared with the receiver
    localparam int unsigned UART_DATA_BITS = 8;

    // Parity bit over a data byte: XOR for even, inverted XOR for odd
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter for bit timing; tick_o is high while the count is zero.
module uart_baud_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Reload on request, otherwise count down and stop at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Counter register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_byte,
    input  logic       i_byte_v,
    output logic       o_tx,
    output logic       o_tx_done,
    output logic       o_busy
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_tx: CLKS_PER_BIT must be in 2..65535");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_DATA  = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]  LAST_STOP  = 3'(STOP_BITS - 1);
    localparam bit          HAS_PARITY = (PARITY != PAR_NONE);

    uart_state_e state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;
    logic        cnt_load;
    logic        tick;

    assign accept = (state_q == ST_IDLE) && i_byte_v;

    uart_baud_cnt #(
        .WIDTH(16)
    ) u_baud_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (cnt_load),
        .load_val_i(BIT_RELOAD),
        .tick_o    (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: advance one bit per counter tick, bytes only accepted in IDLE
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (i_byte_v) state_d = ST_START;
            ST_START:  if (tick) state_d = ST_DATA;
            ST_DATA:   if (tick && bit_idx_q == LAST_DATA) state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick && bit_idx_q == LAST_STOP) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath: next line level, bit index, byte latch, counter reload
    always_comb begin
        data_d    = data_q;
        bit_idx_d = bit_idx_q;
        cnt_load  = 1'b0;
        if (accept) begin
            data_d    = i_byte;
            bit_idx_d = '0;
            cnt_load  = 1'b1;
        end else if (state_q != ST_IDLE && tick && state_d != ST_IDLE) begin
            cnt_load = 1'b1;
            // Index counts data bits, wraps 7->0 on DATA exit, then counts stop bits
            if (state_q == ST_DATA || state_q == ST_STOP) begin
                bit_idx_d = bit_idx_q + 3'd1;
            end
        end

        tx_d = 1'b1;
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_q[bit_idx_d];
            ST_PARITY: tx_d = parity_bit(data_q, PARITY);
            default:   tx_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
    end

    // Registered outputs and datapath; reset returns the line high at once
    // NOTE: the byte latch is reset too so a post-reset frame never sees stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            data_q    <= data_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_busy    = busy_q;
    assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations at 4 clocks per bit.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_i;
    logic       v    [4];
    logic       tx   [4];
    logic       done [4];
    logic       busy [4];

    int n_cmp = 0;
    int n_bad = 0;
    int n_done_seen = 0;

    always #5 clk = ~clk;

    // cfg 0: 8N1, cfg 1: even parity, cfg 2: odd parity, cfg 3: two stop bits
    uart_tx #(.CLKS_PER_BIT(CPB)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_byte(byte_i), .i_byte_v(v[0]),
        .o_tx(tx[0]), .o_tx_done(done[0]), .o_busy(busy[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_byte(byte_i), .i_byte_v(v[1]),
        .o_tx(tx[1]), .o_tx_done(done[1]), .o_busy(busy[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_byte(byte_i), .i_byte_v(v[2]),
        .o_tx(tx[2]), .o_tx_done(done[2]), .o_busy(busy[2]));
    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_byte(byte_i), .i_byte_v(v[3]),
        .o_tx(tx[3]), .o_tx_done(done[3]), .o_busy(busy[3]));

    typedef struct {
        int          cfg;
        logic [7:0]  data;
        logic [11:0] frame;  // line level of bit k in frame[k]
        int          nbits;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Caller has raised v[cfg] at a negedge; acceptance happens on the next posedge.
    // Returns at the negedge of the cycle in which o_tx_done must be high.
    task automatic run_frame(input int cfg, input logic [11:0] exp, input int nbits,
                             input int inject_at, input string tag);
        int          bad_cycles = 0;
        int          early_done = 0;
        logic [11:0] got = '0;
        @(posedge clk);
        for (int k = 0; k < nbits * CPB; k++) begin
            @(negedge clk);
            if (k == 0) v[cfg] = 1'b0;
            if (k == inject_at) begin
                byte_i = 8'h55;
                v[cfg] = 1'b1;
            end
            if (k == inject_at + 1) v[cfg] = 1'b0;
            if (tx[cfg] !== exp[k / CPB]) bad_cycles++;
            if (busy[cfg] !== 1'b1) bad_cycles++;
            if (done[cfg] !== 1'b0) early_done++;
            if (k % CPB == CPB / 2) got[k / CPB] = tx[cfg];
        end
        @(negedge clk);
        if (done[cfg] === 1'b1) n_done_seen++;
        check({tag, " bad line/busy cycles"}, bad_cycles, 0);
        check({tag, " sampled bits"}, got, exp);
        check({tag, " early done"}, early_done, 0);
        check({tag, " done at F"}, done[cfg], 1'b1);
        check({tag, " busy at F"}, busy[cfg], 1'b0);
        check({tag, " line at F"}, tx[cfg], 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] hs_bytes [16];
        int         extra_done;
        int         extra_busy;

        vecs[0] = '{0, 8'h41, 12'h282, 10};
        vecs[1] = '{0, 8'h00, 12'h200, 10};
        vecs[2] = '{0, 8'hFF, 12'h3FE, 10};
        vecs[3] = '{0, 8'hA5, 12'h34A, 10};
        vecs[4] = '{1, 8'h03, 12'h406, 11};
        vecs[5] = '{2, 8'h03, 12'h606, 11};
        vecs[6] = '{1, 8'h07, 12'h60E, 11};
        vecs[7] = '{2, 8'h00, 12'h600, 11};
        vecs[8] = '{3, 8'hFF, 12'h7FE, 11};
        vecs[9] = '{3, 8'h12, 12'h624, 11};

        hs_bytes = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h55,
                     8'h41, 8'h52, 8'h54, 8'h00, 8'hFF, 8'h5A, 8'h0D, 8'h0A};

        rst_n  = 1'b0;
        byte_i = 8'h00;
        for (int i = 0; i < 4; i++) v[i] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset tx[%0d]", i), tx[i], 1'b1);
            check($sformatf("reset busy[%0d]", i), busy[i], 1'b0);
            check($sformatf("reset done[%0d]", i), done[i], 1'b0);
        end
        rst_n = 1'b1;

        // Table of single frames across all configurations
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d idle before", i), {busy[vecs[i].cfg], done[vecs[i].cfg]}, 2'b00);
            byte_i = vecs[i].data;
            v[vecs[i].cfg] = 1'b1;
            run_frame(vecs[i].cfg, vecs[i].frame, vecs[i].nbits, -1, $sformatf("vec%0d", i));
        end

        // Strobe 0x55 mid-frame of 0x41: ignored, no queued frame afterwards
        @(negedge clk);
        byte_i = 8'h41;
        v[0]   = 1'b1;
        run_frame(0, 12'h282, 10, 13, "midframe strobe");
        extra_done = 0;
        extra_busy = 0;
        repeat (8) begin
            @(negedge clk);
            if (done[0] !== 1'b0) extra_done++;
            if (busy[0] !== 1'b0 || tx[0] !== 1'b1) extra_busy++;
        end
        check("midframe no second done", extra_done, 0);
        check("midframe no queued frame", extra_busy, 0);

        // Handshake loop: re-strobe in the done cycle, 16 contiguous frames
        n_done_seen = 0;
        @(negedge clk);
        byte_i = hs_bytes[0];
        v[0]   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            run_frame(0, {2'b00, 1'b1, hs_bytes[i], 1'b0}, 10, -1, $sformatf("hs%0d", i));
            if (i < 15) begin
                byte_i = hs_bytes[i + 1];
                v[0]   = 1'b1;
            end
        end
        check("hs done pulses", n_done_seen, 16);
        @(negedge clk);
        check("hs done one cycle", done[0], 1'b0);

        // Reset during DATA bit 3 of 0xA5 (line low there), then a clean 0x0D frame
        @(negedge clk);
        byte_i = 8'hA5;
        v[0]   = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k == 0) v[0] = 1'b0;
        end
        check("pre-reset line low", tx[0], 1'b0);
        rst_n = 1'b0;
        #1;
        check("reset abort tx", tx[0], 1'b1);
        check("reset abort busy", busy[0], 1'b0);
        extra_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || tx[0] !== 1'b1) extra_done++;
        end
        check("reset no done pulse", extra_done, 0);
        rst_n  = 1'b1;
        byte_i = 8'h0D;
        v[0]   = 1'b1;
        run_frame(0, 12'h21A, 10, -1, "post-reset 0x0D");
        @(negedge clk);
        check("post-reset done one cycle", done[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
